// File: rtl/lvds_panel_sequencer_pkg.sv
// Shared definitions for the LVDS panel path.
//   seq_state_e : power-sequencer state encoding (3 bits, OFF = 0)
//   DEF_*       : default 1280x800 geometry and dwell times for a 72 MHz pixel clock
package lvds_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_VDD_UP   = 3'd1,
    ST_LVDS_UP  = 3'd2,
    ST_RUN      = 3'd3,
    ST_BL_DN    = 3'd4,
    ST_LVDS_DN  = 3'd5,
    ST_VDD_DN   = 3'd6,
    ST_OFF_HOLD = 3'd7
  } seq_state_e;

  localparam int unsigned DEF_H_ACTIVE   = 1280;
  localparam int unsigned DEF_V_ACTIVE   = 800;
  localparam int unsigned DEF_H_BLANK    = 50;
  localparam int unsigned DEF_V_BLANK    = 12;

  localparam int unsigned DEF_T_VDD_LVDS = 720000;    // 10 ms
  localparam int unsigned DEF_T_LVDS_BL  = 14400000;  // 200 ms
  localparam int unsigned DEF_T_BL_LVDS  = 720000;    // 10 ms
  localparam int unsigned DEF_T_LVDS_VDD = 720000;    // 10 ms
  localparam int unsigned DEF_T_OFF_MIN  = 36000000;  // 500 ms
  localparam int unsigned DEF_CNT_W      = 26;

endpackage

// File: rtl/lvds_panel_sequencer_if.sv
// Panel-control and video-timing bundle of the LVDS panel sequencer.
//   panel_on                 : level request, 1 = panel up
//   vdd_en/lvds_en/bl_en     : power enables
//   hsync/vsync (active low), de, pix_x/pix_y, frame_start : raster timing
//   ready                    : panel fully up
// master = requester/consumer side, slave = sequencer side.
interface lvds_panel_sequencer_if;
  logic        panel_on;
  logic        vdd_en;
  logic        lvds_en;
  logic        bl_en;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic        ready;

  modport master (
    output panel_on,
    input  vdd_en, lvds_en, bl_en, hsync, vsync, de, pix_x, pix_y, frame_start, ready
  );

  modport slave (
    input  panel_on,
    output vdd_en, lvds_en, bl_en, hsync, vsync, de, pix_x, pix_y, frame_start, ready
  );
endinterface

// File: rtl/lvds_raster_gen.sv
// Raster timing generator: horizontal/vertical counters with registered
// sync/DE/pixel-position decode.
//   clk, rst_n        : pixel clock, synchronous active-low reset
//   run_i             : counters advance while 1, held at (0,0) while 0
//   frame_end_next_o  : counters sit one clock before the frame wrap
//   hsync_o, vsync_o  : active-low syncs
//   de_o, pix_x_o, pix_y_o, frame_start_o : aligned, one clock after the counters
module lvds_raster_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_BLANK  = 50,
  parameter int unsigned V_ACTIVE = 800,
  parameter int unsigned V_BLANK  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  output logic        frame_end_next_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic        frame_start_o,
  output logic [10:0] pix_x_o,
  output logic [10:0] pix_y_o
);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_BLANK);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_BLANK / 2);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_BLANK);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_BLANK / 2);

  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        de_q, de_d, fs_q, fs_d;

  always_comb begin
    hcnt_d  = '0;
    vcnt_d  = '0;
    pix_x_d = '0;
    pix_y_d = '0;
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    if (run_i) begin
      hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + 11'd1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
      end
      de_d    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hsync_d = !((hcnt_q > H_ACT) && (hcnt_q < H_SYNC_END));
      vsync_d = !((vcnt_q > V_ACT) && (vcnt_q < V_SYNC_END));
      fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
      pix_x_d = hcnt_q;
      pix_y_d = vcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  // Flagged one clock early so the sequencer can drop the stream enable on
  // the very edge the counters wrap, before a new frame_start is issued.
  assign frame_end_next_o = (hcnt_q == H_LAST - 11'd1) && (vcnt_q == V_LAST);

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
endmodule

// File: rtl/lvds_panel_sequencer.sv
// LVDS panel power sequencer and video-timing scheduler.
// Steps the panel through VDD, LVDS stream and backlight with programmable
// dwells and gates the raster so it runs only while the stream is enabled.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   pnl        : panel bundle (slave side) - panel_on in; enables, raster, ready out
module lvds_panel_sequencer
  import lvds_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK    = DEF_H_BLANK,
  parameter int unsigned V_BLANK    = DEF_V_BLANK,
  parameter int unsigned T_VDD_LVDS = DEF_T_VDD_LVDS,
  parameter int unsigned T_LVDS_BL  = DEF_T_LVDS_BL,
  parameter int unsigned T_BL_LVDS  = DEF_T_BL_LVDS,
  parameter int unsigned T_LVDS_VDD = DEF_T_LVDS_VDD,
  parameter int unsigned T_OFF_MIN  = DEF_T_OFF_MIN,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input logic                  clk,
  input logic                  rst_n,
  lvds_panel_sequencer_if.slave pnl
);
  localparam logic [CNT_W-1:0] VDD_LVDS_LAST = CNT_W'(T_VDD_LVDS - 1);
  localparam logic [CNT_W-1:0] LVDS_BL_LAST  = CNT_W'(T_LVDS_BL - 1);
  localparam logic [CNT_W-1:0] BL_LVDS_LAST  = CNT_W'(T_BL_LVDS - 1);
  localparam logic [CNT_W-1:0] LVDS_VDD_LAST = CNT_W'(T_LVDS_VDD - 1);
  localparam logic [CNT_W-1:0] OFF_MIN_LAST  = CNT_W'(T_OFF_MIN - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             lvds_off_q, lvds_off_d;
  logic             vdd_en_q, vdd_en_d, lvds_en_q, lvds_en_d;
  logic             bl_en_q, bl_en_d, ready_q, ready_d;
  logic             frame_end_next;

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q + 1'b1;
    lvds_off_d = lvds_off_q;
    unique case (state_q)
      ST_OFF:      if (pnl.panel_on) state_d = ST_VDD_UP;
      ST_VDD_UP:   if (!pnl.panel_on)                 state_d = ST_VDD_DN;
                   else if (dwell_q == VDD_LVDS_LAST) state_d = ST_LVDS_UP;
      ST_LVDS_UP:  if (!pnl.panel_on)                 state_d = ST_LVDS_DN;
                   else if (dwell_q == LVDS_BL_LAST)  state_d = ST_RUN;
      ST_RUN:      if (!pnl.panel_on) state_d = ST_BL_DN;
      ST_BL_DN:    if (dwell_q == BL_LVDS_LAST) state_d = ST_LVDS_DN;
      // Two phases: wait for the frame wrap with the dwell held at zero,
      // then time T_LVDS_VDD from the clock the stream is switched off.
      ST_LVDS_DN: begin
        if (!lvds_off_q) begin
          dwell_d = '0;
          if (frame_end_next) lvds_off_d = 1'b1;
        end else if (dwell_q == LVDS_VDD_LAST) begin
          state_d = ST_VDD_DN;
        end
      end
      ST_VDD_DN:   state_d = ST_OFF_HOLD;
      ST_OFF_HOLD: if (dwell_q == OFF_MIN_LAST) state_d = ST_OFF;
      default:     state_d = ST_OFF_HOLD;
    endcase
    if (state_d != state_q) begin
      dwell_d    = '0;
      lvds_off_d = 1'b0;
    end

    vdd_en_d  = state_q inside {ST_VDD_UP, ST_LVDS_UP, ST_RUN, ST_BL_DN, ST_LVDS_DN};
    lvds_en_d = (state_q inside {ST_LVDS_UP, ST_RUN, ST_BL_DN}) ||
                ((state_q == ST_LVDS_DN) && !lvds_off_q);
    bl_en_d   = (state_q == ST_RUN);
    ready_d   = (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_OFF_HOLD;
      dwell_q    <= '0;
      lvds_off_q <= 1'b0;
      vdd_en_q   <= 1'b0;
      lvds_en_q  <= 1'b0;
      bl_en_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      lvds_off_q <= lvds_off_d;
      vdd_en_q   <= vdd_en_d;
      lvds_en_q  <= lvds_en_d;
      bl_en_q    <= bl_en_d;
      ready_q    <= ready_d;
    end
  end

  lvds_raster_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .V_BLANK  (V_BLANK)
  ) u_raster (
    .clk              (clk),
    .rst_n            (rst_n),
    .run_i            (lvds_en_q),
    .frame_end_next_o (frame_end_next),
    .hsync_o          (pnl.hsync),
    .vsync_o          (pnl.vsync),
    .de_o             (pnl.de),
    .frame_start_o    (pnl.frame_start),
    .pix_x_o          (pnl.pix_x),
    .pix_y_o          (pnl.pix_y)
  );

  assign pnl.vdd_en  = vdd_en_q;
  assign pnl.lvds_en = lvds_en_q;
  assign pnl.bl_en   = bl_en_q;
  assign pnl.ready   = ready_q;
endmodule
